// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   Dual-bank architectural register file (integer + float, NREG x XLEN each)
//   with a per-register pending-write scoreboard for read-after-write hazards.
//
//   Ports:
//     clk, rstn                 clock (rising edge) / async active-low reset
//     fmode1/reg1 -> reg_out1   read port 1 (combinational, write-through bypass)
//     fmode2/reg2 -> reg_out2   read port 2 (combinational, write-through bypass)
//     busy1, busy2              outstanding-write flag for the addressed register
//     we/wfmode/wreg/wdata      single writeback port from the last stage
//     reserve_en/_fmode/_reg    decode marks a destination register as pending
//
//   Storage is flattened into one array indexed by {fmode, reg}; integer r0
//   is hard-wired to zero and never marked busy.
// -----------------------------------------------------------------------------
module register_file #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     fmode1,
  input  logic                     fmode2,
  input  logic [$clog2(NREG)-1:0]  reg1,
  input  logic [$clog2(NREG)-1:0]  reg2,
  output logic [XLEN-1:0]          reg_out1,
  output logic [XLEN-1:0]          reg_out2,
  output logic                     busy1,
  output logic                     busy2,
  input  logic                     we,
  input  logic                     wfmode,
  input  logic [$clog2(NREG)-1:0]  wreg,
  input  logic [XLEN-1:0]          wdata,
  input  logic                     reserve_en,
  input  logic                     reserve_fmode,
  input  logic [$clog2(NREG)-1:0]  reserve_reg
);

  localparam int AW   = $clog2(NREG);
  localparam int NENT = 2 * NREG;
  localparam logic [NENT-1:0] ONE_HOT0 = NENT'(1);

  logic [NENT-1:0][XLEN-1:0] mem_r;
  logic [NENT-1:0]           busy_r;
  logic [NENT-1:0]           busy_nxt_s;
  logic [NENT-1:0]           clr_mask_s;
  logic [NENT-1:0]           set_mask_s;

  logic [AW:0] wr_idx_s;
  logic [AW:0] rsv_idx_s;
  logic [AW:0] rd_idx1_s;
  logic [AW:0] rd_idx2_s;
  logic        wr_ok_s;
  logic        rsv_ok_s;
  logic        zero1_s;
  logic        zero2_s;
  logic        hit1_s;
  logic        hit2_s;

  assign wr_idx_s  = {wfmode, wreg};
  assign rsv_idx_s = {reserve_fmode, reserve_reg};
  assign rd_idx1_s = {fmode1, reg1};
  assign rd_idx2_s = {fmode2, reg2};

  // Integer r0 is never a real target; rstn gating keeps reset-time traffic
  // from leaking through the bypass or the scoreboard.
  assign wr_ok_s  = rstn & we & (wfmode | (wreg != '0));
  assign rsv_ok_s = rstn & reserve_en & (reserve_fmode | (reserve_reg != '0));
  assign zero1_s  = ~fmode1 & (reg1 == '0);
  assign zero2_s  = ~fmode2 & (reg2 == '0);
  assign hit1_s   = wr_ok_s & (wr_idx_s == rd_idx1_s);
  assign hit2_s   = wr_ok_s & (wr_idx_s == rd_idx2_s);

  // Scoreboard next state: the writeback clears, then a reservation sets, so a
  // same-register collision leaves the register busy.
  always_comb begin
    clr_mask_s = wr_ok_s  ? (ONE_HOT0 << wr_idx_s)  : '0;
    set_mask_s = rsv_ok_s ? (ONE_HOT0 << rsv_idx_s) : '0;
    busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
  end

  // Register storage and scoreboard state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_r  <= '0;
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
      if (wr_ok_s) begin
        mem_r[wr_idx_s] <= wdata;
      end
    end
  end

  // Read port 1: zero in reset / for integer r0, bypass on a same-cycle write.
  always_comb begin
    reg_out1 = '0;
    busy1    = 1'b0;
    if (!rstn || zero1_s) begin
      reg_out1 = '0;
      busy1    = 1'b0;
    end else if (hit1_s) begin
      reg_out1 = wdata;
      busy1    = 1'b0;
    end else begin
      reg_out1 = mem_r[rd_idx1_s];
      busy1    = busy_r[rd_idx1_s];
    end
  end

  // Read port 2: identical to port 1.
  always_comb begin
    reg_out2 = '0;
    busy2    = 1'b0;
    if (!rstn || zero2_s) begin
      reg_out2 = '0;
      busy2    = 1'b0;
    end else if (hit2_s) begin
      reg_out2 = wdata;
      busy2    = 1'b0;
    end else begin
      reg_out2 = mem_r[rd_idx2_s];
      busy2    = busy_r[rd_idx2_s];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Self-checking bench: directed scenarios with literal expectations, then
//   randomized traffic (with occasional mid-cycle resets) compared every
//   negative clock edge against a plain-array reference model.
// -----------------------------------------------------------------------------
module tb_register_file;

  logic        clk;
  logic        rstn;
  logic        fmode1, fmode2;
  logic [4:0]  reg1, reg2;
  logic [31:0] reg_out1, reg_out2;
  logic        busy1, busy2;
  logic        we, wfmode;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        reserve_en, reserve_fmode;
  logic [4:0]  reserve_reg;

  int total = 0;
  int bad   = 0;

  // reference model: [0..31] integer bank, [32..63] float bank
  logic [31:0] m_data [64];
  bit          m_busy [64];

  register_file dut (
    .clk(clk), .rstn(rstn),
    .fmode1(fmode1), .fmode2(fmode2),
    .reg1(reg1), .reg2(reg2),
    .reg_out1(reg_out1), .reg_out2(reg_out2),
    .busy1(busy1), .busy2(busy2),
    .we(we), .wfmode(wfmode), .wreg(wreg), .wdata(wdata),
    .reserve_en(reserve_en), .reserve_fmode(reserve_fmode),
    .reserve_reg(reserve_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int slot(input logic f, input logic [4:0] r);
    return (f ? 32 : 0) + int'(r);
  endfunction

  function automatic bit is_int_r0(input logic f, input logic [4:0] r);
    return (f == 1'b0) && (r == 5'd0);
  endfunction

  function automatic logic [31:0] exp_data(input logic f, input logic [4:0] r);
    if (!rstn || is_int_r0(f, r)) return 32'h0;
    if (we && wfmode == f && wreg == r) return wdata;
    return m_data[slot(f, r)];
  endfunction

  function automatic logic exp_busy(input logic f, input logic [4:0] r);
    if (!rstn || is_int_r0(f, r)) return 1'b0;
    if (we && wfmode == f && wreg == r) return 1'b0;
    return m_busy[slot(f, r)];
  endfunction

  // reference model update: write first, reservation overrides the busy bit
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 64; i++) begin
        m_data[i] = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we && !is_int_r0(wfmode, wreg)) begin
        m_data[slot(wfmode, wreg)] = wdata;
        m_busy[slot(wfmode, wreg)] = 1'b0;
      end
      if (reserve_en && !is_int_r0(reserve_fmode, reserve_reg))
        m_busy[slot(reserve_fmode, reserve_reg)] = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("model_out1",  reg_out1, exp_data(fmode1, reg1));
    chk("model_out2",  reg_out2, exp_data(fmode2, reg2));
    chk("model_busy1", {31'h0, busy1}, {31'h0, exp_busy(fmode1, reg1)});
    chk("model_busy2", {31'h0, busy2}, {31'h0, exp_busy(fmode2, reg2)});
  end

  task automatic idle_in();
    we = 1'b0; wfmode = 1'b0; wreg = 5'd0; wdata = 32'h0;
    reserve_en = 1'b0; reserve_fmode = 1'b0; reserve_reg = 5'd0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rstn = 1'b0;
    fmode1 = 1'b1; reg1 = 5'd3; fmode2 = 1'b0; reg2 = 5'd9;
    idle_in();
    #1;
    chk("rst_out1", reg_out1, 32'h0);
    chk("rst_busy1", {31'h0, busy1}, 32'h0);
    cyc(); cyc();
    rstn = 1'b1;

    // write then read, bank isolation
    cyc();
    we = 1'b1; wfmode = 1'b0; wreg = 5'd3; wdata = 32'h12345678;
    cyc();
    idle_in();
    reg1 = 5'd3; fmode1 = 1'b0; reg2 = 5'd3; fmode2 = 1'b1;
    #1;
    chk("wr_rd_int3", reg_out1, 32'h12345678);
    chk("flt3_clean", reg_out2, 32'h0);

    // reserve float r7, then bypass the writeback
    cyc();
    reserve_en = 1'b1; reserve_fmode = 1'b1; reserve_reg = 5'd7;
    cyc();
    idle_in();
    reg2 = 5'd7; fmode2 = 1'b1;
    #1;
    chk("f7_busy", {31'h0, busy2}, 32'h1);
    we = 1'b1; wfmode = 1'b1; wreg = 5'd7; wdata = 32'hCAFEF00D;
    #1;
    chk("bypass_out2", reg_out2, 32'hCAFEF00D);
    chk("bypass_busy2", {31'h0, busy2}, 32'h0);
    cyc();
    idle_in();
    #1;
    chk("f7_stored", reg_out2, 32'hCAFEF00D);
    chk("f7_cleared", {31'h0, busy2}, 32'h0);

    // integer r0 drops writes and reservations; float r0 is ordinary
    we = 1'b1; wfmode = 1'b0; wreg = 5'd0; wdata = 32'hFFFFFFFF;
    reserve_en = 1'b1; reserve_fmode = 1'b0; reserve_reg = 5'd0;
    reg1 = 5'd0; fmode1 = 1'b0;
    #1;
    chk("r0_out_same", reg_out1, 32'h0);
    chk("r0_busy_same", {31'h0, busy1}, 32'h0);
    cyc();
    idle_in();
    we = 1'b1; wfmode = 1'b1; wreg = 5'd0; wdata = 32'h3F800000;
    #1;
    chk("r0_out_after", reg_out1, 32'h0);
    chk("r0_busy_after", {31'h0, busy1}, 32'h0);
    cyc();
    idle_in();
    fmode1 = 1'b1;
    #1;
    chk("f0_value", reg_out1, 32'h3F800000);

    // scoreboard on integer r9
    reserve_en = 1'b1; reserve_fmode = 1'b0; reserve_reg = 5'd9;
    cyc();
    idle_in();
    reg1 = 5'd9; fmode1 = 1'b0;
    #1;
    chk("r9_busy", {31'h0, busy1}, 32'h1);
    we = 1'b1; wfmode = 1'b0; wreg = 5'd9; wdata = 32'hA5A50009;
    #1;
    chk("r9_wb_busy", {31'h0, busy1}, 32'h0);
    chk("r9_wb_out", reg_out1, 32'hA5A50009);
    cyc();
    idle_in();
    #1;
    chk("r9_after_busy", {31'h0, busy1}, 32'h0);
    chk("r9_after_out", reg_out1, 32'hA5A50009);

    // simultaneous write + reserve
    we = 1'b1; wfmode = 1'b1; wreg = 5'd12; wdata = 32'h1;
    reserve_en = 1'b1; reserve_fmode = 1'b1; reserve_reg = 5'd12;
    cyc();
    idle_in();
    reg1 = 5'd12; fmode1 = 1'b1;
    #1;
    chk("f12_busy", {31'h0, busy1}, 32'h1);
    chk("f12_value", reg_out1, 32'h1);
    we = 1'b1; wfmode = 1'b0; wreg = 5'd5; wdata = 32'h55;
    reserve_en = 1'b1; reserve_fmode = 1'b0; reserve_reg = 5'd4;
    cyc();
    idle_in();
    reg1 = 5'd4; fmode1 = 1'b0; reg2 = 5'd5; fmode2 = 1'b0;
    #1;
    chk("r4_busy", {31'h0, busy1}, 32'h1);
    chk("r5_busy", {31'h0, busy2}, 32'h0);
    chk("r5_value", reg_out2, 32'h55);

    // asynchronous reset between edges
    we = 1'b1; wfmode = 1'b0; wreg = 5'd5; wdata = 32'hDEADBEEF;
    cyc();
    idle_in();
    reg1 = 5'd5; fmode1 = 1'b0; reg2 = 5'd4; fmode2 = 1'b0;
    #1;
    chk("r5_before_rst", reg_out1, 32'hDEADBEEF);
    we = 1'b1; wreg = 5'd5; wdata = 32'h77777777;
    reserve_en = 1'b1; reserve_reg = 5'd6;
    rstn = 1'b0;
    #1;
    chk("async_rst_out1", reg_out1, 32'h0);
    chk("async_rst_busy1", {31'h0, busy1}, 32'h0);
    chk("async_rst_busy2", {31'h0, busy2}, 32'h0);
    cyc();
    idle_in();
    rstn = 1'b1;
    reg2 = 5'd6;
    #1;
    chk("r5_after_rst", reg_out1, 32'h0);
    chk("r6_rsv_dropped", {31'h0, busy2}, 32'h0);

    // randomized traffic; small index range forces collisions
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rstn = ($urandom_range(0, 249) != 0);
      fmode1 = 1'($urandom_range(0, 1));
      fmode2 = 1'($urandom_range(0, 1));
      reg1 = 5'($urandom_range(0, 7));
      reg2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      wfmode = 1'($urandom_range(0, 1));
      wreg = 5'($urandom_range(0, 7));
      wdata = 32'($urandom);
      reserve_en = ($urandom_range(0, 2) == 0);
      reserve_fmode = 1'($urandom_range(0, 1));
      reserve_reg = 5'($urandom_range(0, 7));
    end
    cyc();
    rstn = 1'b1;
    idle_in();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Dual-bank architectural register file: 32 integer and 32 float registers, each 32 bits wide.
- Acts as the responder for the decode stage's read interface, which presents reg1/reg2/fmode1/fmode2 and samples reg_out1/reg_out2 in the same cycle.
- Accepts a single writeback port from the last pipeline stage.
- Keeps a per-register pending-write scoreboard so decode can detect read-after-write hazards.

Parameters:
- NREG, 32, registers per bank; register index width is 5 bits.
- XLEN, 32, register data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- fmode1  input  1  bank select for read port 1 (0 = integer, 1 = float).
- fmode2  input  1  bank select for read port 2.
- reg1  input  5  read port 1 register index.
- reg2  input  5  read port 2 register index.
- reg_out1  output  32  read port 1 data; combinational.
- reg_out2  output  32  read port 2 data; combinational.
- busy1  output  1  register addressed by port 1 has an outstanding write.
- busy2  output  1  register addressed by port 2 has an outstanding write.
- we  input  1  writeback enable.
- wfmode  input  1  writeback bank select.
- wreg  input  5  writeback register index.
- wdata  input  32  writeback data.
- reserve_en  input  1  decode issues an instruction that will write a register.
- reserve_fmode  input  1  bank select for the reservation.
- reserve_reg  input  5  register index for the reservation.

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately when rstn falls, independent of clk.
  - Clears all 64 registers to 32'h0 and all 64 busy bits to 0.
  - While rstn=0, reg_out1 and reg_out2 read 0 and busy1/busy2 read 0; we and reserve_en are ignored.
  - Reset asserted mid-operation discards any in-flight write or reservation in that cycle.
- Integer register 0:
  - Always reads 32'h0.
  - Writes to it are dropped.
  - Reservations of it are dropped, so its busy bit is always 0.
  - Float register 0 is an ordinary register.
- Reads:
  - Purely combinational, with zero latency from reg*/fmode* to reg_out*.
  - Write-through bypass: if we=1, wfmode=fmodeN and wreg=regN (and the target is not integer r0), reg_outN = wdata in the same cycle.
  - Otherwise reg_outN is the stored value.
- Writes:
  - When we=1, bank[wfmode][wreg] <= wdata at the rising edge.
  - The same edge clears busy[wfmode][wreg].
- Reservations:
  - When reserve_en=1, busy[reserve_fmode][reserve_reg] <= 1 at the rising edge.
  - If a write and a reservation target the same register on the same edge, the reservation wins: the busy bit ends at 1 while the data is still updated.
  - Writes and reservations to different registers on the same edge are independent.
- Busy outputs:
  - busyN = busy[fmodeN][regN] AND NOT (we AND wfmode=fmodeN AND wreg=regN).
  - A register being written back this cycle therefore reads not-busy, consistent with the bypass.
  - busyN is forced to 0 for integer r0.
- Scoreboard depth:
  - One bit per register.
  - The pipeline is in-order with a single writeback, so a second reservation of an already-busy register simply leaves the bit at 1.
  - The first matching writeback clears the bit; decode is responsible for stalling so this is safe.
- Bank isolation: integer rN and float rN are distinct storage. A write or reservation in one bank never affects the other.

Test Plan:
- Reset: write int r5=32'hDEADBEEF, then assert rstn=0 between clock edges -> reg_out1 for int r5 reads 0 immediately, before the next edge; busy1=0.
- Write then read: we=1, wfmode=0, wreg=3, wdata=32'h12345678 for one edge; next cycle reg1=3, fmode1=0 -> reg_out1=32'h12345678. Float r3 still reads 0.
- Bypass: same-cycle we=1, wfmode=1, wreg=7, wdata=32'hCAFEF00D with reg2=7, fmode2=1 -> reg_out2=32'hCAFEF00D before the edge; busy2=0.
- Integer r0: write int r0=32'hFFFFFFFF and reserve int r0 -> reg_out1=0 and busy1=0 always. Float r0 written with 32'h3F800000 reads 32'h3F800000.
- Scoreboard:
  - Reserve int r9 -> next cycle busy1=1 for reg1=9.
  - The cycle writeback to int r9 is presented, busy1=0 and reg_out1=wdata.
  - After that edge the bit stays cleared.
- Simultaneous: on one edge, reserve and write float r12 (wdata=32'h1) -> afterwards busy=1 and the stored value is 32'h1. Reserving int r4 while writing int r5 -> r4 busy, r5 not busy.
